pc_fetch_unit: RTL and testbench

- Program-counter and instruction-fetch block for the MIPS core; the consuming end of the single-cycle control unit's PC-steering outputs (PCWrite, Branch, jump, jregister).
- Fetches one instruction word per retirement over a request/valid handshake to instruction memory and presents it to decode.
- On each PCWrite it computes the next PC: sequential, branch, jump or jump-register.
- Also supplies the JAL link address and a retired-instruction counter.

---
 rtl/pc_fetch_unit_if.sv | 24 ++
 rtl/pc_fetch_unit.sv | 131 +++++++++++++
 tb/tb_pc_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch channel: one-cycle request with address, returned
// word qualified by rvalid.
interface pc_fetch_unit_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 imem_req;
  logic [BIT_WIDTH-1:0] imem_addr;
  logic [BIT_WIDTH-1:0] imem_rdata;
  logic                 imem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch for the MIPS core: fetches one word per
// retirement, steers the next PC (sequential/branch/jump/JR) and counts retires.
module pc_fetch_unit #(
  parameter int                   BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC  = 32'h0040_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_fetch_unit_if.master      imem,
  output logic [BIT_WIDTH-1:0] instr,
  output logic                 instr_valid,
  input  logic                 PCWrite,
  input  logic                 Branch,
  input  logic                 branch_cond,
  input  logic                 jump,
  input  logic                 jregister,
  input  logic [BIT_WIDTH-1:0] rs_data,
  output logic [BIT_WIDTH-1:0] pc,
  output logic [BIT_WIDTH-1:0] link_addr,
  output logic [BIT_WIDTH-1:0] instr_count,
  output logic                 misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    EXEC  = 2'd3
  } state_t;

  localparam logic [BIT_WIDTH-1:0] PC_STEP    = BIT_WIDTH'(32'd4);
  localparam logic [BIT_WIDTH-1:0] COUNT_STEP = BIT_WIDTH'(32'd1);

  state_t               state_r;
  logic [BIT_WIDTH-1:0] pc_r;
  logic [BIT_WIDTH-1:0] instr_r;
  logic [BIT_WIDTH-1:0] count_r;
  logic                 misalign_r;
  logic                 req_r;
  logic                 valid_r;

  logic [BIT_WIDTH-1:0] pc_plus4_s;
  logic [BIT_WIDTH-1:0] branch_off_s;
  logic [BIT_WIDTH-1:0] next_pc_s;
  logic                 jr_misaligned_s;

  // Next-PC selection; jregister outranks jump, which outranks a taken branch.
  always_comb begin
    pc_plus4_s      = pc_r + PC_STEP;
    branch_off_s    = {{(BIT_WIDTH-18){instr_r[15]}}, instr_r[15:0], 2'b00};
    jr_misaligned_s = (rs_data[1:0] != 2'b00);
    if (jregister) begin
      next_pc_s = {rs_data[BIT_WIDTH-1:2], 2'b00};
    end else if (jump) begin
      next_pc_s = {pc_plus4_s[BIT_WIDTH-1:28], instr_r[25:0], 2'b00};
    end else if (Branch && branch_cond) begin
      next_pc_s = pc_plus4_s + branch_off_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Fetch/retire FSM; req/valid flags are registered alongside the state so
  // they always equal the decode of the state they accompany.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      pc_r       <= RESET_PC;
      instr_r    <= {BIT_WIDTH{1'b0}};
      count_r    <= {BIT_WIDTH{1'b0}};
      misalign_r <= 1'b0;
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      misalign_r <= 1'b0;
      case (state_r)
        IDLE: begin
          state_r <= FETCH;
          req_r   <= 1'b1;
          valid_r <= 1'b0;
        end
        FETCH: begin
          state_r <= WAIT;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
        WAIT: begin
          // Memory may take arbitrarily long; there is deliberately no timeout.
          if (imem.imem_rvalid) begin
            instr_r <= imem.imem_rdata;
            state_r <= EXEC;
            valid_r <= 1'b1;
          end else begin
            state_r <= WAIT;
            valid_r <= 1'b0;
          end
          req_r <= 1'b0;
        end
        EXEC: begin
          if (PCWrite) begin
            pc_r       <= next_pc_s;
            count_r    <= count_r + COUNT_STEP;
            misalign_r <= jregister && jr_misaligned_s;
            state_r    <= FETCH;
            req_r      <= 1'b1;
            valid_r    <= 1'b0;
          end else begin
            state_r <= EXEC;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign instr          = instr_r;
  assign instr_valid    = valid_r;
  assign pc             = pc_r;
  assign link_addr      = pc_plus4_s;
  assign instr_count    = count_r;
  assign misalign_err   = misalign_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomised bench for pc_fetch_unit: a transaction-level model predicts every
// output each cycle, and literal expectations pin the model on known cases.
module tb_pc_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        PCWrite, Branch, branch_cond, jump, jregister;
  logic [31:0] rs_data;
  logic [31:0] pc, link_addr, instr_count;
  logic        misalign_err;

  pc_fetch_unit_if #(.BIT_WIDTH(32)) imem ();

  pc_fetch_unit #(.BIT_WIDTH(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .imem(imem),
    .instr(instr), .instr_valid(instr_valid),
    .PCWrite(PCWrite), .Branch(Branch), .branch_cond(branch_cond),
    .jump(jump), .jregister(jregister), .rs_data(rs_data),
    .pc(pc), .link_addr(link_addr), .instr_count(instr_count),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference next-PC from the instruction-set rules.
  function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] iw,
                                           input logic br, input logic cond, input logic j,
                                           input logic jr, input logic [31:0] rs);
    logic [31:0] seq;
    int off;
    seq = cur_pc + 32'd4;
    if (jr) return rs & 32'hFFFF_FFFC;
    if (j) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
    if (br && cond) begin
      off = int'($signed(iw[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  // Transaction-level model: a fresh start requests next cycle, a request is
  // followed by waiting for data, data makes an instruction pending until retired.
  bit          m_ready = 1'b0;
  bit          m_boot, m_req, m_wait, m_valid, m_mis;
  logic [31:0] m_pc, m_instr, m_count;

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1'b1; m_boot = 1'b1; m_req = 1'b0; m_wait = 1'b0; m_valid = 1'b0;
      m_mis = 1'b0; m_pc = RST_PC; m_instr = 32'h0; m_count = 32'h0;
    end else if (m_ready) begin
      m_mis = 1'b0;
      if (m_boot) begin
        m_boot = 1'b0; m_req = 1'b1;
      end else if (m_req) begin
        m_req = 1'b0; m_wait = 1'b1;
      end else if (m_wait) begin
        if (imem.imem_rvalid) begin
          m_instr = imem.imem_rdata; m_wait = 1'b0; m_valid = 1'b1;
        end
      end else if (m_valid && PCWrite) begin
        m_mis   = jregister && (rs_data[1:0] != 2'b00);
        m_pc    = ref_next(m_pc, m_instr, Branch, branch_cond, jump, jregister, rs_data);
        m_count = m_count + 32'd1;
        m_valid = 1'b0;
        m_req   = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_ready) begin
      check("imem_req", 32'(imem.imem_req), 32'(m_req));
      check("imem_addr", imem.imem_addr, m_pc);
      check("pc", pc, m_pc);
      check("link_addr", link_addr, m_pc + 32'd4);
      check("instr", instr, m_instr);
      check("instr_valid", 32'(instr_valid), 32'(m_valid));
      check("instr_count", instr_count, m_count);
      check("misalign_err", 32'(misalign_err), 32'(m_mis));
    end
  end

  task automatic pin(input string name, input logic [31:0] act, input logic [31:0] model_v,
                     input logic [31:0] exp);
    check(name, act, exp);
    check({name, "_model"}, model_v, exp);
  endtask

  task automatic clear_ctrl();
    PCWrite = 1'b0; Branch = 1'b0; branch_cond = 1'b0; jump = 1'b0; jregister = 1'b0;
    rs_data = $urandom;
  endtask

  task automatic noise_ctrl();
    PCWrite = 1'($urandom_range(0, 1)); Branch = 1'($urandom_range(0, 1));
    branch_cond = 1'($urandom_range(0, 1)); jump = 1'($urandom_range(0, 1));
    jregister = 1'($urandom_range(0, 1)); rs_data = $urandom;
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic wait_req(output logic [31:0] addr);
    bit ok;
    ok = 1'b0;
    addr = 32'h0;
    for (int i = 0; i < 20; i++) begin
      if (imem.imem_req) begin
        addr = imem.imem_addr; ok = 1'b1; break;
      end
      @(negedge clk);
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] word, input int delay, input bit noisy,
                       output logic [31:0] addr);
    wait_req(addr);
    if (noisy) begin
      imem.imem_rvalid = 1'b1; imem.imem_rdata = $urandom; noise_ctrl();
    end else begin
      imem.imem_rvalid = 1'b0; clear_ctrl();
    end
    @(negedge clk);
    check("misalign_clear", 32'(misalign_err), 32'd0);
    for (int i = 0; i < delay; i++) begin
      imem.imem_rvalid = 1'b0;
      if (noisy) noise_ctrl(); else clear_ctrl();
      @(negedge clk);
    end
    imem.imem_rvalid = 1'b1; imem.imem_rdata = word;
    if (noisy) noise_ctrl(); else clear_ctrl();
    @(negedge clk);
    imem.imem_rvalid = 1'b0; clear_ctrl();
  endtask

  task automatic exec_hold(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      noise_ctrl(); PCWrite = 1'b0;
      imem.imem_rvalid = noisy ? 1'b1 : 1'b0; imem.imem_rdata = $urandom;
      @(negedge clk);
    end
    imem.imem_rvalid = 1'b0; clear_ctrl();
  endtask

  task automatic retire(input logic br, input logic cond, input logic j, input logic jr,
                        input logic [31:0] rs);
    PCWrite = 1'b1; Branch = br; branch_cond = cond; jump = j; jregister = jr; rs_data = rs;
    @(negedge clk);
    clear_ctrl();
  endtask

  task automatic run_instr(input logic [31:0] word, input int delay, input logic br,
                           input logic cond, input logic j, input logic jr, input logic [31:0] rs,
                           input bit noisy, input int hold, output logic [31:0] addr);
    fetch(word, delay, noisy, addr);
    exec_hold(hold, noisy);
    retire(br, cond, j, jr, rs);
  endtask

  task automatic goto_pc(input logic [31:0] target);
    logic [31:0] a;
    run_instr(32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1, target, 1'b0, 0, a);
  endtask

  logic [31:0] addr;
  logic [31:0] exp_addr [3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_addr[0] = 32'h0040_0000; exp_addr[1] = 32'h0040_0004; exp_addr[2] = 32'h0040_0008;
    rst = 1'b1; clear_ctrl(); imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    pin("reset_pc", pc, m_pc, RST_PC);
    pin("reset_count", instr_count, m_count, 32'h0);
    rst = 1'b0;

    // Sequential run from reset
    for (int k = 0; k < 3; k++) begin
      run_instr(32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, addr);
      check("seq_addr", addr, exp_addr[k]);
    end
    pin("seq_count", instr_count, m_count, 32'd3);
    pin("seq_pc", pc, m_pc, 32'h0040_000C);

    // Taken and not-taken branch
    goto_pc(32'h0040_0010);
    pin("jr_pc", pc, m_pc, 32'h0040_0010);
    run_instr(32'h1000_FFFC, 0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, addr);
    pin("br_taken_pc", pc, m_pc, 32'h0040_0004);
    goto_pc(32'h0040_0010);
    run_instr(32'h1000_FFFC, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, addr);
    pin("br_not_taken_pc", pc, m_pc, 32'h0040_0014);

    // JAL target and link address
    goto_pc(32'h0040_0020);
    fetch(32'h0C10_0008, 0, 1'b0, addr);
    check("jal_link", link_addr, 32'h0040_0024);
    retire(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    pin("jal_pc", pc, m_pc, 32'h0040_0020);

    // JR beats jump; misaligned target flags once
    run_instr(32'h0C10_0008, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0040_0102, 1'b0, 0, addr);
    pin("jr_prio_pc", pc, m_pc, 32'h0040_0100);
    pin("jr_misalign", 32'(misalign_err), 32'(m_mis), 32'd1);

    // Stalls with ignored noise on every input
    run_instr(32'h2402_0005, 5, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 4, addr);
    pin("stall_pc", pc, m_pc, 32'h0040_0104);

    // PC wrap
    goto_pc(32'hFFFF_FFFC);
    fetch(32'h0, 0, 1'b0, addr);
    check("wrap_link", link_addr, 32'h0);
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pin("wrap_pc", pc, m_pc, 32'h0);

    // Reset while waiting, then stale rvalid through IDLE and FETCH
    wait_req(addr);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    imem.imem_rvalid = 1'b0;
    pin("midrst_pc", pc, m_pc, RST_PC);
    pin("midrst_count", instr_count, m_count, 32'h0);
    pin("midrst_instr", instr, m_instr, 32'h0);
    pin("midrst_valid", 32'(instr_valid), 32'(m_valid), 32'd0);
    imem.imem_rvalid = 1'b1; imem.imem_rdata = 32'h0;
    @(negedge clk);
    imem.imem_rvalid = 1'b0;
    retire(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pin("post_rst_pc", pc, m_pc, 32'h0040_0004);

    // Randomised traffic
    for (int n = 0; n < 120; n++) begin
      int kind;
      logic [31:0] rs;
      kind = $urandom_range(0, 4);
      rs = $urandom;
      run_instr($urandom, $urandom_range(0, 3),
                1'(kind == 1), 1'($urandom_range(0, 1)),
                1'(kind == 2 || kind == 4), 1'(kind == 3 || kind == 4), rs,
                1'($urandom_range(0, 1)), $urandom_range(0, 2), addr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
